// File: rtl/iir_m_inv.sv
// All-zero inverse of a second-order recursive section: a three-tap FIR over din,
// evaluated sequentially with a single time-shared multiplier, one sample per 6 clocks.
module iir_m_inv #(
   parameter int A0    = 32768,
   parameter int A1    = -31496,
   parameter int A2    = 9456,
   parameter int SHIFT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [17:0] din,
   input  logic               din_valid,
   output logic signed [17:0] dout,
   output logic               dout_valid,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL0 = 3'd1,
      MUL1 = 3'd2,
      MUL2 = 3'd3,
      SUM  = 3'd4,
      OUT  = 3'd5
   } state_t;

   localparam logic signed [17:0] C0 = 18'(A0);
   localparam logic signed [17:0] C1 = 18'(A1);
   localparam logic signed [17:0] C2 = 18'(A2);
   localparam logic signed [37:0] RND = (SHIFT > 0) ? (38'sd1 <<< (SHIFT - 1)) : '0;
   localparam logic signed [37:0] SAT_HI = 38'sd131071;
   localparam logic signed [37:0] SAT_LO = -38'sd131072;

   state_t             state, state_nxt;
   logic signed [17:0] x_cur, x_d1, x_d2;
   logic signed [17:0] coef, opnd;
   logic signed [35:0] prod, p0, p1, p2;
   logic signed [37:0] acc, acc_rnd, acc_sh;
   logic signed [17:0] sat_val;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = din_valid ? MUL0 : IDLE;
         MUL0:    state_nxt = MUL1;
         MUL1:    state_nxt = MUL2;
         MUL2:    state_nxt = SUM;
         SUM:     state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // One multiplier; the tap and delay-line operand are steered by the multiply state.
   always_comb begin
      coef = C0;
      opnd = x_cur;
      case (state)
         MUL1: begin
            coef = C1;
            opnd = x_d1;
         end
         MUL2: begin
            coef = C2;
            opnd = x_d2;
         end
         default: ;
      endcase
   end

   assign prod = coef * opnd;

   // Round half toward +inf, then clip to the 18-bit signed range.
   assign acc_rnd = acc + RND;
   assign acc_sh  = acc_rnd >>> SHIFT;

   always_comb begin
      sat_val = acc_sh[17:0];
      if (acc_sh > SAT_HI)      sat_val = 18'sd131071;
      else if (acc_sh < SAT_LO) sat_val = -18'sd131072;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_cur      <= '0;
         x_d1       <= '0;
         x_d2       <= '0;
         p0         <= '0;
         p1         <= '0;
         p2         <= '0;
         acc        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         case (state)
            IDLE: if (din_valid) x_cur <= din;
            MUL0: p0 <= prod;
            MUL1: p1 <= prod;
            MUL2: p2 <= prod;
            SUM:  acc <= 38'(p0) + 38'(p1) + 38'(p2);
            OUT: begin
               dout       <= sat_val;
               dout_valid <= 1'b1;
               x_d2       <= x_d1;
               x_d1       <= x_cur;
            end
            default: ;
         endcase
      end
   end

endmodule
